alu_op_sequencer: RTL

- Upstream issue stage for the team's combinational 2-bit ALU (ports a, b, sel, result[2:0]; AND/OR/ADD/SUB for sel 00/01/10/11).
- Buffers incoming operations in a small FIFO and presents one operation at a time on registered ALU inputs.
- Captures the ALU result one cycle later and offers it downstream with a valid/ready handshake.
- Results leave in strict arrival order.

---
 rtl/alu_seq_pkg.sv | 23 ++
 rtl/alu_op_fifo.sv | 61 ++++++
 rtl/alu_op_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module : alu_seq_pkg
// Brief  : Shared opcode constants and FSM encoding for the ALU op sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_op_fifo.sv
// ============================================================================
// Module : alu_op_fifo
// Brief  : Power-of-two synchronous FIFO with occupancy count and full flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_op_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CW   = PTRW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTRW-1:0]  r_wptr;
    logic [PTRW-1:0]  r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // Requests are ignored when they cannot be honoured, so the pointers stay coherent.
    assign w_push = push && (r_count != CW'(DEPTH));
    assign w_pop  = pop  && (r_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTRW'(1);
            if (w_pop)  r_rptr <= r_rptr + PTRW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= wdata;
    end

    assign rdata = r_mem[r_rptr];
    assign count = r_count;
    assign full  = (r_count == CW'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// Module : alu_op_sequencer
// Brief  : Queues ALU operations, issues them one at a time on registered ALU
//          inputs and returns captured results in order via valid/ready.
//          Optional macro ALU_SEQ_STATS_EN adds done_cnt and stall outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int OPW   = 2,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           op_valid,
    output logic           op_ready,
    input  logic [OPW-1:0] op_a,
    input  logic [OPW-1:0] op_b,
    input  logic [1:0]     op_sel,
    output logic [OPW-1:0] alu_a,
    output logic [OPW-1:0] alu_b,
    output logic [1:0]     alu_sel,
    input  logic [OPW:0]   alu_result,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [OPW:0]   res_data,
    output logic [1:0]     res_sel
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [7:0]     done_cnt,
    output logic           stall
`endif
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int EW   = 2*OPW + 2;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_pop;
    logic             w_capture;
    logic             w_res_clr;
    logic             w_push;
    logic             w_full;
    logic             w_empty;
    logic [PTRW:0]    w_count;
    logic [EW-1:0]    w_rdata;
    logic [OPW-1:0]   r_alu_a;
    logic [OPW-1:0]   r_alu_b;
    logic [1:0]       r_alu_sel;
    logic             r_res_valid;
    logic [OPW:0]     r_res_data;
    logic [1:0]       r_res_sel;

    assign op_ready = !w_full;
    assign w_push   = op_valid && op_ready;
    assign w_empty  = (w_count == '0);

    alu_op_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .wdata ({op_a, op_b, op_sel}),
        .rdata (w_rdata),
        .count (w_count),
        .full  (w_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_res_clr   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_capture   = 1'b1;
                w_state_nxt = HOLD;
            end
            HOLD: begin
                // res_valid is always set in HOLD, so res_ready alone completes the handshake.
                if (res_ready) begin
                    w_res_clr = 1'b1;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ISSUE;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_sel   <= '0;
        end else begin
            if (w_pop) begin
                r_alu_a   <= w_rdata[EW-1 -: OPW];
                r_alu_b   <= w_rdata[OPW+1 -: OPW];
                r_alu_sel <= w_rdata[1:0];
            end
            if (w_capture) begin
                r_res_data  <= alu_result;
                r_res_sel   <= r_alu_sel;
                r_res_valid <= 1'b1;
            end else if (w_res_clr) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_sel   = r_alu_sel;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_sel   = r_res_sel;

`ifdef ALU_SEQ_STATS_EN
    logic [7:0] r_done_cnt;
    logic       r_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_cnt <= '0;
            r_stall    <= 1'b0;
        end else begin
            if (r_res_valid && res_ready) r_done_cnt <= r_done_cnt + 8'd1;
            r_stall <= op_valid && !op_ready;
        end
    end

    assign done_cnt = r_done_cnt;
    assign stall    = r_stall;
`endif

endmodule

`default_nettype wire
